// File: rtl/cic_nr16_pkg.sv
// Shared constants and types for the 3-stage PDM-to-PCM CIC decimator.
// R = 2^LOG2R, internal word width W = N*LOG2R + 1 bits.
package cic_pkg;

  localparam int CIC_N     = 3;
  localparam int CIC_LOG2R = 5;
  localparam int CIC_W     = CIC_N * CIC_LOG2R + 1;
  localparam int CIC_R     = 1 << CIC_LOG2R;

  // DC gain R^N. For a constant-1 input the output settles to this value.
  localparam int CIC_GAIN  = 1 << (CIC_N * CIC_LOG2R);

  typedef logic [CIC_W-1:0] acc_t;

endpackage

// File: rtl/cic_nr16_if.sv
// PDM input and PCM output bundle for the CIC decimator.
// master drives clkdiv and x_in; slave (the filter) drives y_out.
interface cic_nr16_if;

  logic        clkdiv;
  logic        x_in;
  logic [15:0] y_out;

  modport master (output clkdiv, output x_in, input y_out);
  modport slave  (input clkdiv, input x_in, output y_out);

endinterface

// File: rtl/cic_nr16_comb_stage.sv
// One CIC comb section with differential delay 1: c_o = c_i - c_i(previous strobe).
// The delay register advances only when en is high.
module cic_comb_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] c_o
);

  logic [W-1:0] dly_q;
  logic [W-1:0] dly_d;

  always_comb begin
    dly_d = dly_q;
    if (en) dly_d = c_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dly_q <= '0;
    else     dly_q <= dly_d;
  end

  // Modulo-2^W subtraction; wrap-around in the integrators cancels here.
  assign c_o = c_i - dly_q;

endmodule

// File: rtl/cic_nr16.sv
// Three-stage CIC decimator: 1-bit PDM in, 16-bit unsigned PCM out.
// Integrators run every clk; combs and the output register update on clkdiv rising edges.
module cic_nr16
  import cic_pkg::*;
#(
  parameter int N     = CIC_N,
  parameter int LOG2R = CIC_LOG2R,
  parameter int W     = N * LOG2R + 1
) (
  input  logic         clk,
  input  logic         rst,
  cic_nr16_if.slave    pdm
);

  logic         clkdiv_q;
  logic         dec_en;
  logic [W-1:0] integ_q [N];
  logic [W-1:0] integ_d [N];
  logic [W-1:0] comb_w  [N+1];
  logic [15:0]  y_q;
  logic [15:0]  y_d;

  // Strobe: one clk wide, high while clkdiv reads 1 and read 0 at the previous edge.
  // clkdiv_q resets to 1 so a clkdiv already high at reset release is not a strobe.
  assign dec_en = pdm.clkdiv & ~clkdiv_q;

  always_comb begin
    integ_d[0] = integ_q[0] + W'(pdm.x_in);
    for (int j = 1; j < N; j++) begin
      integ_d[j] = integ_q[j] + integ_q[j-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkdiv_q <= 1'b1;
      for (int j = 0; j < N; j++) integ_q[j] <= '0;
    end else begin
      clkdiv_q <= pdm.clkdiv;
      for (int j = 0; j < N; j++) integ_q[j] <= integ_d[j];
    end
  end

  assign comb_w[0] = integ_q[N-1];

  for (genvar g = 0; g < N; g++) begin : g_comb
    cic_comb_stage #(.W(W)) u_comb (
      .clk (clk),
      .rst (rst),
      .en  (dec_en),
      .c_i (comb_w[g]),
      .c_o (comb_w[g+1])
    );
  end

  always_comb begin
    y_d = y_q;
    if (dec_en) y_d = comb_w[N][15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign pdm.y_out = y_q;

endmodule

// File: tb/tb_cic_nr16.sv
// Bench for cic_nr16: directed phases plus random PDM, checked against a closed-form
// model (third difference of the triple running sum of the input history).
module tb_cic_nr16;
  import cic_pkg::*;

  localparam int M_ONES  = 0;
  localparam int M_ZEROS = 1;
  localparam int M_ALT   = 2;
  localparam int M_RAND  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cic_nr16_if pdm_if ();

  cic_nr16 dut (
    .clk (clk),
    .rst (rst),
    .pdm (pdm_if)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  bit          xh[$];
  acc_t        sq[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_y;
  bit          cd_prev;
  bit          strobe_seen;
  logic [4:0]  div_cnt;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Value of the last integrator after e clk edges: sum of x_i * C(e-1-i, 2).
  function automatic logic [15:0] i3_at(input int e);
    longint sum = 0;
    longint n;
    for (int i = 0; i < e; i++) begin
      if (xh[i]) begin
        n = longint'(e - 1 - i);
        sum += n * (n - 1) / 2;
      end
    end
    return sum[15:0];
  endfunction

  // Three cascaded first differences of the strobe samples, zero before reset.
  function automatic logic [15:0] delta3();
    int n;
    int a;
    int b;
    int c;
    int d;
    int t;
    n = sq.size();
    a = (n > 0) ? int'(sq[n-1]) : 0;
    b = (n > 1) ? int'(sq[n-2]) : 0;
    c = (n > 2) ? int'(sq[n-3]) : 0;
    d = (n > 3) ? int'(sq[n-4]) : 0;
    t = a - 3 * b + 3 * c - d;
    return t[15:0];
  endfunction

  task automatic model_clear();
    xh.delete();
    sq.delete();
    exp_q.delete();
    exp_y   = '0;
    cd_prev = 1'b1;
  endtask

  // Driver: called at a negedge; drives one cycle and checks y_out at the next negedge.
  task automatic step(input bit x, input bit cd);
    pdm_if.x_in   = x;
    pdm_if.clkdiv = cd;
    @(posedge clk);
    strobe_seen = cd && !cd_prev;
    cd_prev     = cd;
    if (strobe_seen) begin
      sq.push_back(i3_at(xh.size()));
      exp_q.push_back(delta3());
    end
    xh.push_back(x);
    @(negedge clk);
    if (strobe_seen) begin
      exp_y = exp_q.pop_front();
      check16("y_strobe", pdm_if.y_out, exp_y);
    end else begin
      check16("y_hold", pdm_if.y_out, exp_y);
    end
  endtask

  // Asserts reset between clk edges and checks the output clears without a clk edge.
  task automatic do_reset(input bit cd_at_release);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check16("y_async_rst", pdm_if.y_out, 16'd0);
    pdm_if.clkdiv = cd_at_release;
    pdm_if.x_in   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check16("y_in_rst", pdm_if.y_out, 16'd0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic run_phase(input int mode, input int nstr, input logic [15:0] cval,
                           input int cfrom);
    int got;
    int cyc;
    bit x;
    got = 0;
    cyc = 0;
    while (got < nstr && cyc < nstr * 32 + 64) begin
      case (mode)
        M_ONES:  x = 1'b1;
        M_ZEROS: x = 1'b0;
        M_ALT:   x = (cyc % 2 == 0);
        default: x = 1'($urandom_range(0, 1));
      endcase
      step(x, div_cnt[4]);
      div_cnt++;
      cyc++;
      if (strobe_seen) begin
        got++;
        if (cfrom > 0 && got >= cfrom) check16("y_const", pdm_if.y_out, cval);
      end
    end
  endtask

  initial begin
    pdm_if.clkdiv = 1'b0;
    pdm_if.x_in   = 1'b0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    check16("y_reset", pdm_if.y_out, 16'd0);
    rst = 1'b0;
    model_clear();

    // Constant ones: settles to full-scale gain.
    div_cnt = '0;
    run_phase(M_ONES, 12, 16'd32768, 5);

    // clkdiv frozen low: output holds, integrators keep running.
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0);
      check16("y_freeze", pdm_if.y_out, 16'd32768);
    end
    div_cnt = '0;
    run_phase(M_ONES, 8, 16'd32768, 5);

    // Mid-stream reset, then constant zeros.
    do_reset(1'b0);
    div_cnt = '0;
    run_phase(M_ZEROS, 8, 16'd0, 1);

    // Alternating 1,0: half scale.
    do_reset(1'b0);
    div_cnt = '0;
    run_phase(M_ALT, 10, 16'd16384, 5);

    // Random PDM against the model.
    do_reset(1'b0);
    div_cnt = '0;
    run_phase(M_RAND, 15, 16'd0, 0);

    // clkdiv high at release: first strobe only after a low-then-high transition.
    do_reset(1'b1);
    div_cnt = 5'd16;
    run_phase(M_ONES, 1, 16'd4960, 1);
    run_phase(M_ONES, 8, 16'd32768, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
